// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the CNN pipeline: sequences feature extractor, flatten buffer
// and FC layer, gathers NUM_OUT FC beats and reports the signed argmax with a valid/ready hold.

module cnn_frame_lane #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module cnn_frame_sequencer #(
    parameter int RESULT_W    = 48,
    parameter int NUM_OUT     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = $clog2(NUM_OUT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         fe_done,
    input  logic                         buf_full,
    input  logic                         fc_valid,
    input  logic [RESULT_W-1:0]          fc_data,
    input  logic                         res_ready,
    output logic                         fe_start,
    output logic                         fc_start,
    output logic                         res_valid,
    output logic [NUM_OUT*RESULT_W-1:0]  res_data,
    output logic [IDX_W-1:0]             res_argmax,
    output logic [RESULT_W-1:0]          res_max,
    output logic                         busy,
    output logic [1:0]                   err_flags,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, CONV, WAIT_BUF, FC_START, FC_COLLECT, RESULT} state_t;

    state_t                             state;
    logic [WD_W-1:0]                    wd;
    logic [IDX_W-1:0]                   beat_cnt, run_idx, nxt_idx;
    logic signed [RESULT_W-1:0]         run_max, nxt_max;
    logic [NUM_OUT-1:0][RESULT_W-1:0]   lanes;
    logic beat_we, last_beat, new_max, wait_st, exit_cond, wd_exp, timeout;
    logic do_abort, b2b, lane_clr;

    assign do_abort  = abort && (state != IDLE);
    assign beat_we   = (state == FC_COLLECT) && fc_valid && !abort;
    assign last_beat = beat_we && (beat_cnt == IDX_W'(NUM_OUT - 1));
    // First beat seeds the running max so all-negative frames resolve correctly.
    assign new_max   = (beat_cnt == '0) || ($signed(fc_data) > run_max);
    assign nxt_max   = new_max ? $signed(fc_data) : run_max;
    assign nxt_idx   = new_max ? beat_cnt : run_idx;

    assign wait_st   = (state == CONV) || (state == WAIT_BUF) || (state == FC_COLLECT);
    assign exit_cond = ((state == CONV) && fe_done) || ((state == WAIT_BUF) && buf_full) || last_beat;
    assign wd_exp    = (wd == WD_W'(TIMEOUT_CYC - 1));
    assign timeout   = wait_st && !exit_cond && wd_exp;
    assign b2b       = (state == RESULT) && res_ready && start && !abort;
    assign lane_clr  = (state == FC_START) || do_abort;

    assign busy      = (state != IDLE);
    assign res_data  = lanes;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        cnn_frame_lane #(.W(RESULT_W)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .we  (beat_we && (beat_cnt == IDX_W'(k))),
            .d   (fc_data),
            .q   (lanes[k])
        );
    end

    // Watchdog restarts on every state change and only runs in the waiting states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd <= '0;
        else if (wait_st && !exit_cond && !do_abort && !wd_exp) wd <= wd + 1'b1;
        else wd <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (start && (state != IDLE) && !b2b && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fe_start   <= 1'b0;
            fc_start   <= 1'b0;
            res_valid  <= 1'b0;
            res_argmax <= '0;
            res_max    <= '0;
            err_flags  <= 2'b00;
            frame_cnt  <= '0;
            beat_cnt   <= '0;
            run_idx    <= '0;
            run_max    <= '0;
        end else begin
            fe_start <= 1'b0;
            fc_start <= 1'b0;
            if (do_abort) begin
                state        <= IDLE;
                res_valid    <= 1'b0;
                err_flags[1] <= 1'b1;
            end else if (timeout) begin
                state        <= IDLE;
                err_flags[0] <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state     <= CONV;
                        fe_start  <= 1'b1;
                        err_flags <= 2'b00;
                    end
                    CONV:     if (fe_done) state <= WAIT_BUF;
                    WAIT_BUF: if (buf_full) begin
                        state    <= FC_START;
                        fc_start <= 1'b1;
                    end
                    FC_START: begin
                        state    <= FC_COLLECT;
                        beat_cnt <= '0;
                        run_idx  <= '0;
                        run_max  <= '0;
                    end
                    FC_COLLECT: if (beat_we) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        run_idx  <= nxt_idx;
                        run_max  <= nxt_max;
                        if (last_beat) begin
                            state      <= RESULT;
                            res_valid  <= 1'b1;
                            res_argmax <= nxt_idx;
                            res_max    <= nxt_max;
                            frame_cnt  <= frame_cnt + 1'b1;
                        end
                    end
                    RESULT: if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            state     <= CONV;
                            fe_start  <= 1'b1;
                            err_flags <= 2'b00;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: nominal, ties/negatives, backpressure,
// back-to-back, timeout, abort and asynchronous reset.

module tb_cnn_frame_sequencer;
    localparam int RW = 48;
    localparam int NO = 4;
    localparam int DW = NO * RW;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 0, abort = 0, fe_done = 0, buf_full = 0, fc_valid = 0, res_ready = 0;
    logic [RW-1:0] fc_data = '0;
    logic fe_start, fc_start, res_valid, busy;
    logic [DW-1:0] res_data;
    logic [1:0] res_argmax, err_flags;
    logic [RW-1:0] res_max;
    logic [15:0] frame_cnt, drop_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic [RW-1:0] mx;
        logic [15:0]   fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int n_tests = 0, n_fail = 0;
    logic [15:0] frames = 0;

    cnn_frame_sequencer #(.RESULT_W(RW), .NUM_OUT(NO), .TIMEOUT_CYC(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fe_done(fe_done),
        .buf_full(buf_full), .fc_valid(fc_valid), .fc_data(fc_data), .res_ready(res_ready),
        .fe_start(fe_start), .fc_start(fc_start), .res_valid(res_valid), .res_data(res_data),
        .res_argmax(res_argmax), .res_max(res_max), .busy(busy), .err_flags(err_flags),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [NO-1:0][RW-1:0] b, input logic [15:0] fc);
        exp_t e;
        e.data = b;
        e.idx  = 2'd0;
        e.mx   = b[0];
        for (int k = 1; k < NO; k++)
            if ($signed(b[k]) > $signed(e.mx)) begin
                e.idx = 2'(k);
                e.mx  = b[k];
            end
        e.fc = fc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results are consumed here, on the falling edge, whenever the handshake completes.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_argmax", {190'd0, res_argmax}, {190'd0, e.idx});
                chk("res_max", {144'd0, res_max}, {144'd0, e.mx});
                chk("frame_cnt", {176'd0, frame_cnt}, {176'd0, e.fc});
            end
        end
    end

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
        chk("fe_start_pulse", {191'd0, fe_start}, 1);
        chk("busy_on_start", {191'd0, busy}, 1);
    endtask

    // Drives a frame from CONV onward with immediate fe_done/buf_full responses.
    task automatic run_frame(input logic [NO-1:0][RW-1:0] b);
        fe_done = 1;
        tick();
        fe_done = 0;
        chk("fe_start_once", {191'd0, fe_start}, 0);
        buf_full = 1;
        tick();
        buf_full = 0;
        chk("fc_start_pulse", {191'd0, fc_start}, 1);
        tick();
        chk("fc_start_once", {191'd0, fc_start}, 0);
        frames++;
        cur = model(b, frames);
        exp_q.push_back(cur);
        for (int k = 0; k < NO; k++) begin
            fc_valid = 1;
            fc_data  = b[k];
            tick();
        end
        fc_valid = 0;
        chk("res_valid_set", {191'd0, res_valid}, 1);
    endtask

    task automatic accept();
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("res_valid_clr", {191'd0, res_valid}, 0);
        chk("idle_after_acc", {191'd0, busy}, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, {191'd0, busy}, 0);
        chk({tag, "_valid"}, {191'd0, res_valid}, 0);
        chk({tag, "_fe"}, {191'd0, fe_start}, 0);
        chk({tag, "_fc"}, {191'd0, fc_start}, 0);
        chk({tag, "_data"}, res_data, 0);
        chk({tag, "_max"}, {144'd0, res_max}, 0);
        chk({tag, "_arg"}, {190'd0, res_argmax}, 0);
        chk({tag, "_err"}, {190'd0, err_flags}, 0);
        chk({tag, "_fcnt"}, {176'd0, frame_cnt}, 0);
        chk({tag, "_dcnt"}, {176'd0, drop_cnt}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NO-1:0][RW-1:0] b;
        tick();
        tick();
        check_idle_zero("reset");
        rst = 0;
        tick();

        // Nominal frame, held under backpressure with a dropped start in the middle.
        b = {48'd7, 48'd300, -48'sd5, 48'd10};
        do_start();
        run_frame(b);
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            tick();
            start = 0;
            chk("hold_valid", {191'd0, res_valid}, 1);
            chk("hold_data", res_data, cur.data);
            chk("hold_arg", {190'd0, res_argmax}, {190'd0, cur.idx});
            chk("hold_max", {144'd0, res_max}, {144'd0, cur.mx});
            if (c == 5) chk("no_fe_on_drop", {191'd0, fe_start}, 0);
        end
        chk("drop_cnt", {176'd0, drop_cnt}, 1);
        chk("argmax_nom", {190'd0, res_argmax}, 2);
        chk("max_nom", {144'd0, res_max}, 300);
        accept();

        // Ties and negatives, then a back-to-back start on accept.
        b = {-48'sd8, -48'sd1, -48'sd1, -48'sd3};
        do_start();
        run_frame(b);
        chk("argmax_tie", {190'd0, res_argmax}, 1);
        chk("max_neg", {144'd0, res_max}, {144'd0, -48'sd1});
        res_ready = 1;
        start = 1;
        tick();
        res_ready = 0;
        start = 0;
        chk("b2b_fe_start", {191'd0, fe_start}, 1);
        chk("b2b_busy", {191'd0, busy}, 1);
        chk("b2b_no_drop", {176'd0, drop_cnt}, 1);
        for (int k = 0; k < NO; k++) b[k] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        b[3] = b[1];
        run_frame(b);
        accept();

        // Watchdog: buf_full never rises.
        do_start();
        fe_done = 1;
        tick();
        fe_done = 0;
        for (int c = 0; c < 15; c++) tick();
        chk("to_still_busy", {191'd0, busy}, 1);
        tick();
        chk("to_idle", {191'd0, busy}, 0);
        chk("to_err", {190'd0, err_flags}, 2'b01);
        chk("to_no_result", {191'd0, res_valid}, 0);

        // Abort after two beats; the start also clears the timeout flag.
        do_start();
        chk("flags_cleared", {190'd0, err_flags}, 0);
        fe_done = 1;
        tick();
        fe_done = 0;
        buf_full = 1;
        tick();
        buf_full = 0;
        tick();
        for (int k = 0; k < 2; k++) begin
            fc_valid = 1;
            fc_data  = 48'd100 + 48'(k);
            tick();
        end
        fc_valid = 0;
        abort = 1;
        tick();
        abort = 0;
        chk("abort_idle", {191'd0, busy}, 0);
        chk("abort_err", {190'd0, err_flags}, 2'b10);
        chk("abort_fcnt", {176'd0, frame_cnt}, {176'd0, frames});
        chk("abort_no_result", {191'd0, res_valid}, 0);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_idle_noop", {190'd0, err_flags}, 2'b10);

        // Asynchronous reset in the middle of FC_COLLECT.
        do_start();
        fe_done = 1;
        tick();
        fe_done = 0;
        buf_full = 1;
        tick();
        buf_full = 0;
        tick();
        fc_valid = 1;
        fc_data  = 48'd55;
        tick();
        fc_valid = 0;
        #1 rst = 1;
        #1;
        check_idle_zero("async_rst");
        tick();
        rst = 0;
        tick();

        chk("sb_drained", {160'd0, 32'(exp_q.size())}, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
